gray_fifo_ctrl: RTL and testbench
=================================

Name: gray_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences an external simple-dual-port RAM (1-cycle read latency) using Gray-coded read/write pointers.
- Provides valid/ready handshakes on both sides, a 2-entry first-word-fall-through output skid buffer, and occupancy/status flags.
- Registered Gray pointers are exported so a later async-FIFO variant can reuse this block unchanged.

Parameters:
- DATA_WIDTH, 8, payload width.
- ADDR_WIDTH, 4, RAM address width; RAM depth = 2^ADDR_WIDTH.
- AFULL_THRESH, 12, almost_full asserts when level >= this value.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous discard of all contents.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted.
- wr_data  in  DATA_WIDTH  write payload.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  DATA_WIDTH  head-of-queue word.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_WIDTH  RAM write address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  ADDR_WIDTH  RAM read address.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_re.
- wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer.
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer.
- level  out  ADDR_WIDTH+2  total words held (RAM + in-flight + skid).
- full  out  1  RAM full.
- empty  out  1  level == 0.
- almost_full  out  1  level >= AFULL_THRESH.

Behaviour:
- Pointers:
  - wr_bin and rd_bin are ADDR_WIDTH+1 bits and wrap modulo 2^(ADDR_WIDTH+1).
  - Each Gray pointer is registered in the same cycle as its binary pointer, as gray = bin ^ (bin >> 1).
  - Consecutive values of a Gray pointer differ in exactly 1 bit, including across the wrap.
- Flags, derived from the Gray pointers:
  - RAM empty when wr_ptr_gray == rd_ptr_gray.
  - full when wr_ptr_gray == {~rd_ptr_gray[top two bits], rd_ptr_gray[remaining bits]}.
- Write side:
  - wr_ready = ~full.
  - Write fire = wr_valid & wr_ready.
  - On fire: mem_we = 1, mem_waddr = wr_bin[ADDR_WIDTH-1:0], mem_wdata = wr_data (all combinational), and wr_bin increments.
  - wr_valid while full: ignored, no state change.
- Read side (prefetch engine):
  - Skid holds skid_cnt entries (0..2); pend = read issued last cycle.
  - Issue mem_re when RAM non-empty & ~flush & (skid_cnt + pend - rd_fire) < 2.
  - mem_raddr = rd_bin low bits; rd_bin increments on issue.
  - The cycle after issue, mem_rdata is pushed into the skid tail.
  - rd_valid = (skid_cnt != 0); rd_data = skid head; rd_fire = rd_valid & rd_ready.
  - Push and pop in the same cycle are allowed.
  - Sustained throughput is 1 word/cycle.
- Latency: a write into an empty FIFO appears on rd_valid 3 cycles after the write fire cycle (write → issue → data → skid).
- level:
  - Registered; equals (wr_bin - rd_bin) + pend + skid_cnt.
  - Increments on write fire and decrements on rd_fire.
  - Unchanged when both occur in the same cycle.
  - Maximum value is 2^ADDR_WIDTH + 2.
- Simultaneous write and read issue on the same RAM address cannot occur, since RAM non-empty is required to issue.
- Flush (priority over all other events):
  - Next cycle: both pointers = 0, skid_cnt = 0, pend = 0, level = 0.
  - In-flight mem_rdata is dropped.
  - mem_we and mem_re are forced to 0 during the flush cycle.
- Reset: same state as flush; all outputs 0 except wr_ready = 1 and empty = 1. Reset mid-transfer discards all data.
- No write-side pointer or RAM state changes on a flush cycle even if wr_valid = 1.

Test Plan:
- Reset, then single write 0xA5 at cycle 0 → mem_we at cycle 0 with waddr 0; mem_re at cycle 1; rd_valid = 1 with rd_data = 0xA5 at cycle 3; level = 1 from cycle 1.
- Fill 16 writes with rd_ready = 0 → 2 words move to skid; wr_ready falls after 18 accepted writes; full = 1; level = 18; almost_full = 1 from level 12.
- Streaming writes 0..39 with rd_ready = 1 continuously → outputs 0..39 in order, one per cycle after 3-cycle fill, no bubbles; pointers wrap past 31 correctly.
- Check every rd_ptr_gray/wr_ptr_gray change across 64 increments → exactly one bit toggles each step, including 31 → 0 (10000 → 00000).
- Flush while level = 7 with a read in flight → next cycle level = 0, empty = 1, rd_valid = 0, Gray pointers = 0; the next write 0x3C is returned first.
- Random wr_valid/rd_ready at 50% for 2000 cycles against a scoreboard → no loss, duplication or reorder; level matches model every cycle.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 1-cycle-latency SDP RAM via Gray pointers,
// with a 2-entry first-word-fall-through output skid buffer and occupancy flags.
module gray_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;

  logic [PW-1:0]         wr_bin, rd_bin, wr_bin_nxt, rd_bin_nxt;
  logic                  pend;
  logic [1:0]            skid_cnt;
  logic                  skid_head;
  logic                  skid_tail;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  ram_empty;
  logic                  wr_fire, rd_fire, rd_issue;
  logic [2:0]            skid_after;

  assign ram_empty = (wr_ptr_gray == rd_ptr_gray);
  assign full      = (wr_ptr_gray == {~rd_ptr_gray[PW-1:PW-2], rd_ptr_gray[PW-3:0]});
  assign wr_ready  = ~full;

  // Flush and reset both suppress RAM traffic in the cycle they are asserted.
  assign wr_fire   = wr_valid & ~full & ~flush & resetn;
  assign mem_we    = wr_fire;
  assign mem_waddr = wr_bin[ADDR_WIDTH-1:0];
  assign mem_wdata = wr_fire ? wr_data : '0;

  assign rd_valid  = (skid_cnt != 2'd0);
  assign rd_data   = skid_mem[skid_head];
  assign rd_fire   = rd_valid & rd_ready;

  // Skid occupancy once the outstanding read lands and this cycle's pop retires.
  assign skid_after = {1'b0, skid_cnt} + {2'b0, pend} - {2'b0, rd_fire};
  assign rd_issue   = ~ram_empty & ~flush & resetn & (skid_after < 3'd2);
  assign mem_re     = rd_issue;
  assign mem_raddr  = rd_bin[ADDR_WIDTH-1:0];

  assign wr_bin_nxt = wr_bin + PW'(1);
  assign rd_bin_nxt = rd_bin + PW'(1);
  // A push only ever finds at most one resident entry, so the tail is the slot after the head.
  assign skid_tail  = skid_head ^ skid_cnt[0];

  assign empty       = (level == '0);
  assign almost_full = (level >= LW'(AFULL_THRESH));

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_bin      <= '0;
      rd_bin      <= '0;
      wr_ptr_gray <= '0;
      rd_ptr_gray <= '0;
      pend        <= 1'b0;
      skid_cnt    <= 2'd0;
      skid_head   <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      level       <= '0;
    end else begin
      if (wr_fire) begin
        wr_bin      <= wr_bin_nxt;
        wr_ptr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      end
      if (rd_issue) begin
        rd_bin      <= rd_bin_nxt;
        rd_ptr_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      end
      pend      <= rd_issue;
      skid_cnt  <= skid_after[1:0];
      skid_head <= skid_head ^ rd_fire;
      if (pend) skid_mem[skid_tail] <= mem_rdata;
      level <= level + LW'(wr_fire) - LW'(rd_fire);
    end
  end
endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Randomized and directed checks of gray_fifo_ctrl against a queue-based reference model.
module tb_gray_fifo_ctrl;
  logic       clk = 1'b0;
  logic       resetn, flush, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [7:0] wr_data, rd_data, mem_wdata, mem_rdata;
  logic       mem_we, mem_re, full, empty, almost_full;
  logic [3:0] mem_waddr, mem_raddr;
  logic [4:0] wr_ptr_gray, rd_ptr_gray;
  logic [5:0] level;
  logic [7:0] ram [16];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // Behavioural RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_raddr];
    else        mem_rdata <= 8'hxx;
  end

  gray_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .level(level),
    .full(full), .empty(empty), .almost_full(almost_full)
  );

  function automatic logic [4:0] gray_of(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i + 8'h40); tick();
    end
    wr_valid = 1'b0; tick();
    resetn = 1'b0; tick(); tick(); #1;
    tests++;
    if ({level, empty, wr_ready, rd_valid, full, almost_full, mem_we, mem_re} !== {6'd0, 7'b1100000}
        || wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0 || rd_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: level=%0d empty=%b wr_ready=%b rd_valid=%b full=%b af=%b we=%b re=%b wg=%b rg=%b rd_data=%h, required level=0 empty=1 wr_ready=1 others 0",
               level, empty, wr_ready, rd_valid, full, almost_full, mem_we, mem_re, wr_ptr_gray, rd_ptr_gray, rd_data);
    end
    resetn = 1'b1;
    tick(); #1;
    tests++;
    if (rd_valid !== 1'b0 || level !== 6'd0) begin
      fails++; $display("FAIL reset_discard: rd_valid=%b level=%0d, required 0 and 0", rd_valid, level);
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    wr_valid = 1'b1; wr_data = 8'hA5; #1;
    tests++;
    if (mem_we !== 1'b1 || mem_waddr !== 4'd0 || mem_wdata !== 8'hA5 || level !== 6'd0) begin
      fails++; $display("FAIL single_c0: we=%b waddr=%0d wdata=%h level=%0d, required 1 0 a5 0", mem_we, mem_waddr, mem_wdata, level);
    end
    tick(); wr_valid = 1'b0; #1;
    tests++;
    if (mem_re !== 1'b1 || mem_raddr !== 4'd0 || level !== 6'd1 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL single_c1: re=%b raddr=%0d level=%0d rd_valid=%b, required 1 0 1 0", mem_re, mem_raddr, level, rd_valid);
    end
    tick(); #1;
    tests++;
    if (rd_valid !== 1'b0 || level !== 6'd1) begin
      fails++; $display("FAIL single_c2: rd_valid=%b level=%0d, required 0 1", rd_valid, level);
    end
    tick(); rd_ready = 1'b1; #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      fails++; $display("FAIL single_c3: rd_valid=%b rd_data=%h, required 1 a5", rd_valid, rd_data);
    end
    tick(); rd_ready = 1'b0; #1;
    tests++;
    if (level !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      fails++; $display("FAIL single_drain: level=%0d empty=%b rd_valid=%b, required 0 1 0", level, empty, rd_valid);
    end
  endtask

  task automatic test_fill();
    int acc = 0, got = 0;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      wr_valid = 1'b1; wr_data = 8'(acc); #1;
      tests++;
      if (wr_ready !== (acc < 18) || level !== 6'(acc) || almost_full !== (acc >= 12) || full !== (acc >= 18)) begin
        fails++; $display("FAIL fill_c%0d: wr_ready=%b level=%0d af=%b full=%b, required %b %0d %b %b",
                          c, wr_ready, level, almost_full, full, acc < 18, acc, acc >= 12, acc >= 18);
      end
      if (wr_ready) acc++;
      tick();
    end
    tests++;
    if (acc != 18) begin
      fails++; $display("FAIL fill_accepted: got %0d writes, required 18", acc);
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int c = 0; c < 40 && got < 18; c++) begin
      #1;
      if (rd_valid) begin
        tests++;
        if (rd_data !== 8'(got)) begin
          fails++; $display("FAIL fill_drain_%0d: rd_data=%0d, required %0d", got, rd_data, got);
        end
        got++;
      end
      tick();
    end
    rd_ready = 1'b0;
    tests++;
    if (got != 18 || level !== 6'd0) begin
      fails++; $display("FAIL fill_drain_count: got %0d level=%0d, required 18 and 0", got, level);
    end
  endtask

  task automatic test_back_to_back();
    int nexp = 0;
    apply_reset();
    rd_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      wr_valid = (c < 40); wr_data = 8'(c); #1;
      if (rd_valid) begin
        tests++;
        if (rd_data !== 8'(nexp) || c != nexp + 3) begin
          fails++; $display("FAIL stream_%0d: data=%0d at cycle %0d, required %0d at cycle %0d", nexp, rd_data, c, nexp, nexp + 3);
        end
        nexp++;
      end
      tick();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    tests++;
    if (nexp != 40) begin
      fails++; $display("FAIL stream_count: %0d words out, required 40", nexp);
    end
  endtask

  task automatic test_gray();
    int writes = 0, rd_changes = 0;
    logic [4:0] prev_w, prev_r;
    apply_reset();
    rd_ready = 1'b1;
    prev_w = wr_ptr_gray; prev_r = rd_ptr_gray;
    for (int c = 0; c < 80; c++) begin
      wr_valid = (c < 70); wr_data = 8'(c); #1;
      if (wr_valid && wr_ready) writes++;
      tick();
      tests++;
      if (wr_ptr_gray !== gray_of(writes) || (wr_ptr_gray !== prev_w && $countones(wr_ptr_gray ^ prev_w) != 1)) begin
        fails++; $display("FAIL gray_wr_%0d: %b (prev %b), required %b", writes, wr_ptr_gray, prev_w, gray_of(writes));
      end
      if (rd_ptr_gray !== prev_r) begin
        rd_changes++;
        tests++;
        if ($countones(rd_ptr_gray ^ prev_r) != 1) begin
          fails++; $display("FAIL gray_rd_step: %b -> %b, required one-bit change", prev_r, rd_ptr_gray);
        end
      end
      prev_w = wr_ptr_gray; prev_r = rd_ptr_gray;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    tests++;
    if (writes != 70 || rd_changes != 70 || rd_ptr_gray !== gray_of(70)) begin
      fails++; $display("FAIL gray_totals: writes=%0d rd_steps=%0d rd_gray=%b, required 70 70 %b", writes, rd_changes, rd_ptr_gray, gray_of(70));
    end
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h10 + i); tick();
    end
    wr_valid = 1'b0; tick(); tick(); tick();
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1; #1;
    tests++;
    if (mem_re !== 1'b1 || level !== 6'd7) begin
      fails++; $display("FAIL flush_setup: re=%b level=%0d, required 1 7", mem_re, level);
    end
    tick();
    rd_ready = 1'b0; flush = 1'b1; wr_data = 8'h99; #1;
    tests++;
    if (level !== 6'd7 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      fails++; $display("FAIL flush_cycle: level=%0d we=%b re=%b, required 7 0 0", level, mem_we, mem_re);
    end
    tick();
    flush = 1'b0; wr_valid = 1'b0; #1;
    tests++;
    if (level !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || wr_ptr_gray !== 5'd0 || rd_ptr_gray !== 5'd0) begin
      fails++; $display("FAIL flush_after: level=%0d empty=%b rd_valid=%b wg=%b rg=%b, required 0 1 0 0 0",
                        level, empty, rd_valid, wr_ptr_gray, rd_ptr_gray);
    end
    wr_valid = 1'b1; wr_data = 8'h3C; tick(); wr_valid = 1'b0;
    tick(); #1;
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL flush_stale: rd_valid=%b data=%h, required 0", rd_valid, rd_data);
    end
    tick(); #1;
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || level !== 6'd1) begin
      fails++; $display("FAIL flush_next: rd_valid=%b data=%h level=%0d, required 1 3c 1", rd_valid, rd_data, level);
    end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int bad = 0;
    apply_reset();
    for (int c = 0; c < 2030; c++) begin
      wr_valid = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_ready = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = 8'($urandom);
      #1;
      tests++;
      if ((q.size() < 16 && wr_ready !== 1'b1) || (q.size() >= 18 && wr_ready !== 1'b0)) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL rand_wr_ready c%0d: wr_ready=%b with %0d held", c, wr_ready, q.size());
      end
      if (rd_valid && rd_ready) begin
        tests++;
        if (q.size() == 0 || rd_data !== q[0]) begin
          fails++; bad++;
          if (bad < 10) $display("FAIL rand_data c%0d: rd_data=%h, required %h (held %0d)", c, rd_data, (q.size() != 0) ? q[0] : 8'h00, q.size());
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (wr_valid && wr_ready) q.push_back(wr_data);
      tick();
      tests++;
      if (level !== 6'(q.size()) || empty !== (q.size() == 0) || almost_full !== (q.size() >= 12)) begin
        fails++; bad++;
        if (bad < 10) $display("FAIL rand_level c%0d: level=%0d empty=%b af=%b, required %0d", c, level, empty, almost_full, q.size());
      end
    end
    rd_ready = 1'b0;
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL rand_drain: %0d words never delivered, required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_back_to_back();
    test_gray();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
